// File: rtl/ifetch_pfb_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pfb_pkg : shared types and constants for the instruction prefetch buffer
// Revision: 1.0
// ============================================================================
package ifetch_pfb_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [1:0]  FETCH_SIZE_WORD = 2'd2;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t data;
  } pfb_entry_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pfb_if.sv
`default_nettype none
// ============================================================================
// ifetch_pfb_if : core-side fetch port and ROM-side bus bundles
// Revision: 1.0
// ============================================================================
interface ifetch_pfb_core_if;
  import ifetch_pfb_pkg::*;

  logic  redirect;
  word_t redirect_pc;
  logic  instr_valid;
  logic  instr_ready;
  word_t instr_data;
  word_t instr_pc;

  modport master (
    output redirect, redirect_pc, instr_ready,
    input  instr_valid, instr_data, instr_pc
  );

  modport slave (
    input  redirect, redirect_pc, instr_ready,
    output instr_valid, instr_data, instr_pc
  );
endinterface

interface ifetch_pfb_mem_if;
  import ifetch_pfb_pkg::*;

  logic       mem_valid;
  word_t      mem_addr;
  logic       mem_write;
  logic [1:0] mem_size;
  word_t      mem_wdata;
  logic       mem_ready;
  word_t      mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_write, mem_size, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_write, mem_size, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_pfb_fifo.sv
`default_nettype none
// ============================================================================
// pfb_fifo : synchronous {pc,data} FIFO with flush; head is zero when empty
// Revision: 1.0
// ============================================================================
module pfb_fifo
  import ifetch_pfb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          flush_i,
  input  wire logic          push_i,
  input  wire pfb_entry_t    push_entry_i,
  input  wire logic          pop_i,
  output logic [CW-1:0]      count_o,
  output logic               valid_o,
  output pfb_entry_t         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  pfb_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // A pop in the flush cycle still completes; only the push is discarded.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/ifetch_pfb.sv
`default_nettype none
// ============================================================================
// ifetch_pfb : sequential instruction prefetch buffer with redirect flush
// Revision: 1.0
// ============================================================================
module ifetch_pfb
  import ifetch_pfb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ifetch_pfb_core_if.slave   core,
  ifetch_pfb_mem_if.master   mem
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  word_t         fetch_pc_q, fetch_pc_d;
  word_t         tag_pc_q,   tag_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q,     drop_d;
  logic [CW-1:0] count;
  logic          fifo_valid;
  logic          issue;
  logic          push;
  logic          pop;
  pfb_entry_t    head;
  pfb_entry_t    push_entry;

  // Credit counts the outstanding request so a response always has a slot.
  assign issue      = ~rst & ((count + CW'(inflight_q)) < CW'(DEPTH));
  assign push       = mem.mem_ready & inflight_q & ~drop_q;
  assign pop        = core.instr_ready & fifo_valid;
  assign push_entry = '{pc: tag_pc_q, data: mem.mem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = 1'b0;
    drop_d     = 1'b0;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end
    // Redirect wins: the request issued this cycle still goes out, but its
    // response is never pushed.
    if (core.redirect) begin
      fetch_pc_d = word_align(core.redirect_pc);
      inflight_d = 1'b0;
      drop_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  pfb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (core.redirect),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .valid_o      (fifo_valid),
    .head_o       (head)
  );

  assign core.instr_valid = fifo_valid;
  assign core.instr_data  = head.data;
  assign core.instr_pc    = head.pc;

  assign mem.mem_valid = issue;
  assign mem.mem_addr  = fetch_pc_q;
  assign mem.mem_write = 1'b0;
  assign mem.mem_size  = FETCH_SIZE_WORD;
  assign mem.mem_wdata = '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_pfb.sv
`default_nettype none
// ============================================================================
// tb_ifetch_pfb : directed bench for ifetch_pfb against a one-cycle ROM model
// Revision: 1.0
// ============================================================================
module tb_ifetch_pfb;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ifetch_pfb_core_if core_if ();
  ifetch_pfb_mem_if  mem_if ();

  ifetch_pfb #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM: word at address A holds A/4, returned one cycle after the request.
  always @(posedge clk) begin
    if (rst) begin
      mem_if.mem_ready <= 1'b0;
      mem_if.mem_rdata <= '0;
    end else begin
      mem_if.mem_ready <= mem_if.mem_valid;
      mem_if.mem_rdata <= {2'b00, mem_if.mem_addr[31:2]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst                 = 1'b1;
    core_if.redirect    = 1'b0;
    core_if.redirect_pc = '0;
    core_if.instr_ready = 1'b0;

    cyc(); cyc(); #1;
    chk("rst_mem_valid",   32'(mem_if.mem_valid),   32'd0);
    chk("rst_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("rst_instr_data",  core_if.instr_data,       32'd0);
    chk("rst_instr_pc",    core_if.instr_pc,         32'd0);
    chk("mem_write",       32'(mem_if.mem_write),    32'd0);
    chk("mem_size",        32'(mem_if.mem_size),     32'd2);
    chk("mem_wdata",       mem_if.mem_wdata,         32'd0);

    // Streaming from reset
    cyc(); rst = 1'b0; core_if.instr_ready = 1'b1; #1;
    chk("c0_mem_valid",   32'(mem_if.mem_valid),    32'd1);
    chk("c0_mem_addr",    mem_if.mem_addr,          32'h0);
    chk("c0_instr_valid", 32'(core_if.instr_valid), 32'd0);
    cyc(); #1;
    chk("c1_mem_addr",    mem_if.mem_addr,          32'h4);
    chk("c1_instr_valid", 32'(core_if.instr_valid), 32'd0);
    for (int k = 2; k < 8; k++) begin
      cyc(); #1;
      chk("stream_valid", 32'(core_if.instr_valid), 32'd1);
      chk("stream_pc",    core_if.instr_pc,         32'(4 * (k - 2)));
      chk("stream_data",  core_if.instr_data,       32'(k - 2));
      chk("stream_addr",  mem_if.mem_addr,          32'(4 * k));
    end

    // Core stall: four words buffered, issue stops
    cyc(); core_if.instr_ready = 1'b0; #1;
    chk("c8_pc",   core_if.instr_pc, 32'd24);
    chk("c8_addr", mem_if.mem_addr,  32'd32);
    cyc(); #1;
    chk("c9_valid", 32'(mem_if.mem_valid), 32'd1);
    chk("c9_addr",  mem_if.mem_addr,       32'd36);
    for (int c = 10; c < 18; c++) begin
      cyc(); #1;
      chk("stall_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    end
    chk("stall_head_pc", core_if.instr_pc, 32'd24);
    cyc(); core_if.instr_ready = 1'b1; #1;
    chk("c18_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("c18_pc",        core_if.instr_pc,      32'd24);
    for (int c = 19; c < 24; c++) begin
      cyc(); #1;
      chk("resume_pc",        core_if.instr_pc,      32'(24 + 4 * (c - 18)));
      chk("resume_data",      core_if.instr_data,    32'(6 + (c - 18)));
      chk("resume_mem_valid", 32'(mem_if.mem_valid), 32'd1);
      chk("resume_addr",      mem_if.mem_addr,       32'(40 + 4 * (c - 19)));
    end

    // Redirect to 0x103 while a pop handshakes
    cyc(); core_if.redirect = 1'b1; core_if.redirect_pc = 32'h0000_0103; #1;
    chk("c24_pc",   core_if.instr_pc, 32'd48);
    chk("c24_addr", mem_if.mem_addr,  32'd60);
    cyc(); core_if.redirect = 1'b0; #1;
    chk("c25_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c25_addr",        mem_if.mem_addr,          32'h100);
    cyc(); #1;
    chk("c26_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c26_addr",        mem_if.mem_addr,          32'h104);
    cyc(); #1;
    chk("c27_instr_valid", 32'(core_if.instr_valid), 32'd1);
    chk("c27_pc",          core_if.instr_pc,         32'h100);
    chk("c27_data",        core_if.instr_data,       32'h40);
    cyc(); #1;
    chk("c28_pc",   core_if.instr_pc,   32'h104);
    chk("c28_data", core_if.instr_data, 32'h41);

    // Back-to-back redirects: 0x40 then 0x80
    cyc(); core_if.redirect = 1'b1; core_if.redirect_pc = 32'h40; #1;
    chk("c29_pc", core_if.instr_pc, 32'h108);
    cyc(); core_if.redirect_pc = 32'h80; #1;
    chk("c30_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c30_addr",        mem_if.mem_addr,          32'h40);
    cyc(); core_if.redirect = 1'b0; #1;
    chk("c31_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c31_addr",        mem_if.mem_addr,          32'h80);
    cyc(); #1;
    chk("c32_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c32_addr",        mem_if.mem_addr,          32'h84);
    cyc(); #1;
    chk("c33_pc",   core_if.instr_pc,   32'h80);
    chk("c33_data", core_if.instr_data, 32'h20);
    cyc(); #1;
    chk("c34_pc", core_if.instr_pc, 32'h84);

    // Address wrap at the top of the space
    cyc(); core_if.redirect = 1'b1; core_if.redirect_pc = 32'hFFFF_FFF8; #1;
    chk("c35_pc", core_if.instr_pc, 32'h88);
    cyc(); core_if.redirect = 1'b0; #1;
    chk("c36_addr", mem_if.mem_addr, 32'hFFFF_FFF8);
    cyc(); #1;
    chk("c37_addr", mem_if.mem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("wrap_addr", mem_if.mem_addr,    32'h0);
    chk("c38_pc",    core_if.instr_pc,   32'hFFFF_FFF8);
    chk("c38_data",  core_if.instr_data, 32'h3FFF_FFFE);
    cyc(); #1;
    chk("c39_pc",   core_if.instr_pc,   32'hFFFF_FFFC);
    chk("c39_data", core_if.instr_data, 32'h3FFF_FFFF);
    chk("c39_addr", mem_if.mem_addr,    32'h4);
    cyc(); #1;
    chk("c40_pc",   core_if.instr_pc,   32'h0);
    chk("c40_data", core_if.instr_data, 32'h0);

    // Reset mid-stream
    cyc(); rst = 1'b1; #1;
    chk("c41_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    cyc(); #1;
    chk("c42_instr_valid", 32'(core_if.instr_valid), 32'd0);
    chk("c42_instr_data",  core_if.instr_data,       32'd0);
    chk("c42_instr_pc",    core_if.instr_pc,         32'd0);
    chk("c42_mem_valid",   32'(mem_if.mem_valid),    32'd0);
    cyc(); rst = 1'b0; #1;
    chk("c43_mem_valid",   32'(mem_if.mem_valid),    32'd1);
    chk("c43_addr",        mem_if.mem_addr,          32'h0);
    chk("c43_instr_valid", 32'(core_if.instr_valid), 32'd0);
    cyc(); #1;
    chk("c44_addr", mem_if.mem_addr, 32'h4);
    cyc(); #1;
    chk("c45_instr_valid", 32'(core_if.instr_valid), 32'd1);
    chk("c45_pc",          core_if.instr_pc,         32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
